// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR controller: CSR addresses,
// instruction op codes, controller states, mstatus field positions and
// reset values, plus a small op-code legality helper.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_RW   = 4'd1,
        OP_RS   = 4'd2,
        OP_RC   = 4'd3,
        OP_RWI  = 4'd4,
        OP_RSI  = 4'd5,
        OP_RCI  = 4'd6
    } csr_op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        T_EPC,
        T_CAUSE,
        T_STAT,
        MRET
    } state_e;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_0000_0000_1800;
    localparam logic [63:0] CSR_RST     = 64'h0;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op >= OP_RW) && (op <= OP_RCI);
    endfunction

endpackage

// File: rtl/csr_rmw.sv
// Combinational read-modify-write datapath for CSR instructions.
// Ports:
//   op_i   - CSR op code (1 rw, 2 rs, 3 rc, 4 rwi, 5 rsi, 6 rci)
//   old_i  - current CSR value
//   rs1_i  - register operand
//   imm_i  - 5-bit uimm, zero-extended
//   new_o  - value to be written back (old value for unknown ops)
module csr_rmw
    import csr_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [63:0] old_i,
    input  logic [63:0] rs1_i,
    input  logic [4:0]  imm_i,
    output logic [63:0] new_o
);

    logic [63:0] imm64;

    always_comb begin
        imm64 = {59'b0, imm_i};
        new_o = old_i;
        case (op_i)
            OP_RW:   new_o = rs1_i;
            OP_RS:   new_o = old_i | rs1_i;
            OP_RC:   new_o = old_i & ~rs1_i;
            OP_RWI:  new_o = imm64;
            OP_RSI:  new_o = old_i | imm64;
            OP_RCI:  new_o = old_i & ~imm64;
            default: new_o = old_i;
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: executes CSR instructions, sequences trap
// entry over three cycles and handles mret, producing PC redirects.
// Optional feature: define CSR_PERF_CNT_EN to add mcycle (0xB00) and
// minstret (0xB02); without it those addresses are illegal.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   ready                    - high in IDLE; requests accepted on that edge
//   csr_req/op/addr/rs1/imm  - CSR instruction request and operands
//   csr_done/rd_val/illegal  - one-cycle completion with old value
//   trap_req/cause/pc/tval   - trap entry request and its information
//   mret_req                 - return-from-trap request
//   instret                  - instruction retire pulse
//   redirect_valid/pc        - one-cycle PC redirect
module csr_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        csr_req,
    input  logic [3:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_rs1,
    input  logic [4:0]  csr_imm,
    output logic        csr_done,
    output logic [63:0] csr_rd_val,
    output logic        csr_illegal,
    input  logic        trap_req,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        mret_req,
    input  logic        instret,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    state_e      state_q;
    logic        ready_q, csr_done_q, csr_illegal_q, redirect_valid_q;
    logic [63:0] csr_rd_val_q, redirect_pc_q;

    // Captured request operands
    logic [3:0]  op_q;
    logic [11:0] addr_q;
    logic [63:0] rs1_q;
    logic [4:0]  imm_q;
    logic [63:0] tpc_q, tcause_q, ttval_q;

    // Architectural state
    logic        st_mie_q, st_mpie_q;
    logic [63:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
`ifdef CSR_PERF_CNT_EN
    logic [63:0] mcycle_q, minstret_q;
`else
    logic        unused_instret;
    assign unused_instret = instret;
`endif

    logic [63:0] mstatus_rd, rd_data, csr_new_d, trap_target_d;
    logic        rd_legal;

    always_comb begin
        mstatus_rd = CSR_RST;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MIE]  = st_mie_q;
        mstatus_rd[MSTATUS_MPIE] = st_mpie_q;
    end

    // Read mux is only consulted at acceptance; the sampled value is both the
    // returned rd_val and the old value fed to the RMW datapath in EXEC.
    always_comb begin
        rd_data  = CSR_RST;
        rd_legal = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  rd_data = mstatus_rd;
            ADDR_MIE:      rd_data = mie_q;
            ADDR_MTVEC:    rd_data = mtvec_q;
            ADDR_MSCRATCH: rd_data = mscratch_q;
            ADDR_MEPC:     rd_data = mepc_q;
            ADDR_MCAUSE:   rd_data = mcause_q;
            ADDR_MTVAL:    rd_data = mtval_q;
`ifdef CSR_PERF_CNT_EN
            ADDR_MCYCLE:   rd_data = mcycle_q;
            ADDR_MINSTRET: rd_data = minstret_q;
`else
            ADDR_MCYCLE, ADDR_MINSTRET: rd_legal = 1'b0;
`endif
            default:       rd_legal = 1'b0;
        endcase
    end

    // Vectored mode only applies to interrupts; exceptions use the base.
    always_comb begin
        trap_target_d = {mtvec_q[63:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && tcause_q[63])
            trap_target_d = {mtvec_q[63:2], 2'b00} + {tcause_q[61:0], 2'b00};
    end

    csr_rmw u_rmw (
        .op_i  (op_q),
        .old_i (csr_rd_val_q),
        .rs1_i (rs1_q),
        .imm_i (imm_q),
        .new_o (csr_new_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            ready_q          <= 1'b1;
            csr_done_q       <= 1'b0;
            csr_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            csr_rd_val_q     <= '0;
            redirect_pc_q    <= '0;
            op_q             <= '0;
            addr_q           <= '0;
            rs1_q            <= '0;
            imm_q            <= '0;
            tpc_q            <= '0;
            tcause_q         <= '0;
            ttval_q          <= '0;
            st_mie_q         <= MSTATUS_RST[MSTATUS_MIE];
            st_mpie_q        <= MSTATUS_RST[MSTATUS_MPIE];
            mie_q            <= CSR_RST;
            mtvec_q          <= CSR_RST;
            mscratch_q       <= CSR_RST;
            mepc_q           <= CSR_RST;
            mcause_q         <= CSR_RST;
            mtval_q          <= CSR_RST;
`ifdef CSR_PERF_CNT_EN
            mcycle_q         <= CSR_RST;
            minstret_q       <= CSR_RST;
`endif
        end else begin
            csr_done_q       <= 1'b0;
            csr_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
`ifdef CSR_PERF_CNT_EN
            // A counter write in EXEC below overrides these increments.
            mcycle_q <= mcycle_q + 64'd1;
            if (instret)
                minstret_q <= minstret_q + 64'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        tpc_q    <= trap_pc;
                        tcause_q <= trap_cause;
                        ttval_q  <= trap_tval;
                        ready_q  <= 1'b0;
                        state_q  <= T_EPC;
                    end else if (mret_req) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                        ready_q          <= 1'b0;
                        state_q          <= MRET;
                    end else if (csr_req) begin
                        op_q          <= csr_op;
                        addr_q        <= csr_addr;
                        rs1_q         <= csr_rs1;
                        imm_q         <= csr_imm;
                        csr_done_q    <= 1'b1;
                        csr_illegal_q <= ~(rd_legal & op_is_legal(csr_op));
                        csr_rd_val_q  <= (rd_legal & op_is_legal(csr_op)) ? rd_data : '0;
                        ready_q       <= 1'b0;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!csr_illegal_q) begin
                        case (addr_q)
                            ADDR_MSTATUS: begin
                                st_mie_q  <= csr_new_d[MSTATUS_MIE];
                                st_mpie_q <= csr_new_d[MSTATUS_MPIE];
                            end
                            ADDR_MIE:      mie_q      <= csr_new_d;
                            ADDR_MTVEC:    mtvec_q    <= csr_new_d[1] ? {csr_new_d[63:2], 2'b00} : csr_new_d;
                            ADDR_MSCRATCH: mscratch_q <= csr_new_d;
                            ADDR_MEPC:     mepc_q     <= {csr_new_d[63:2], 2'b00};
                            ADDR_MCAUSE:   mcause_q   <= csr_new_d;
                            ADDR_MTVAL:    mtval_q    <= csr_new_d;
`ifdef CSR_PERF_CNT_EN
                            ADDR_MCYCLE:   mcycle_q   <= csr_new_d;
                            ADDR_MINSTRET: minstret_q <= csr_new_d;
`endif
                            default: ;
                        endcase
                    end
                    csr_rd_val_q <= '0;
                    ready_q      <= 1'b1;
                    state_q      <= IDLE;
                end
                T_EPC: begin
                    mepc_q  <= {tpc_q[63:2], 2'b00};
                    state_q <= T_CAUSE;
                end
                T_CAUSE: begin
                    mcause_q         <= tcause_q;
                    mtval_q          <= ttval_q;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= trap_target_d;
                    state_q          <= T_STAT;
                end
                T_STAT: begin
                    st_mpie_q <= st_mie_q;
                    st_mie_q  <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                MRET: begin
                    st_mie_q  <= st_mpie_q;
                    st_mpie_q <= 1'b1;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready          = ready_q;
    assign csr_done       = csr_done_q;
    assign csr_rd_val     = csr_rd_val_q;
    assign csr_illegal    = csr_illegal_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: expected completions and redirects are
// queued when stimulus is driven and compared by a monitor when the DUT
// produces them; scenario tasks also check timing and reset behaviour.
module tb_csr_ctrl;

    localparam logic [3:0] RW = 4'd1, RS = 4'd2, RC = 4'd3, RWI = 4'd4, RSI = 4'd5, RCI = 4'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready;
    logic        csr_req = 1'b0;
    logic [3:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_rs1 = '0;
    logic [4:0]  csr_imm = '0;
    logic        csr_done;
    logic [63:0] csr_rd_val;
    logic        csr_illegal;
    logic        trap_req = 1'b0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_pc = '0;
    logic [63:0] trap_tval = '0;
    logic        mret_req = 1'b0;
    logic        instret = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       nm;
        logic [63:0] v;
        logic        ill;
        logic        any;
    } exp_t;

    exp_t exp_q[$];
    exp_t rdr_q[$];
    exp_t me, mr;

    always #5 clk = ~clk;

    csr_ctrl dut (
        .clk(clk), .rst(rst), .ready(ready),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_rs1(csr_rs1), .csr_imm(csr_imm),
        .csr_done(csr_done), .csr_rd_val(csr_rd_val), .csr_illegal(csr_illegal),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret_req(mret_req), .instret(instret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (csr_done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_done: rd_val=%h illegal=%b, expected no completion", csr_rd_val, csr_illegal);
                end else begin
                    me = exp_q.pop_front();
                    if ((!me.any && csr_rd_val !== me.v) || csr_illegal !== me.ill)
                        $display("FAIL %s: rd_val=%h illegal=%b, expected rd_val=%h illegal=%b",
                                 me.nm, csr_rd_val, csr_illegal, me.v, me.ill);
                    else
                        n_pass++;
                end
            end else if (csr_illegal) begin
                n_checks++;
                $display("FAIL illegal_without_done: csr_illegal=1 expected 0");
            end
            if (redirect_valid) begin
                n_checks++;
                if (rdr_q.size() == 0) begin
                    $display("FAIL unexpected_redirect: redirect_pc=%h, expected no redirect", redirect_pc);
                end else begin
                    mr = rdr_q.pop_front();
                    if (redirect_pc !== mr.v)
                        $display("FAIL %s: redirect_pc=%h expected %h", mr.nm, redirect_pc, mr.v);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic run_csr(input string nm, input logic [3:0] op, input logic [11:0] addr,
                           input logic [63:0] rs1, input logic [4:0] imm,
                           input logic [63:0] erd, input logic eill, input logic any = 1'b0);
        int n;
        exp_q.push_back('{nm, erd, eill, any});
        @(negedge clk);
        n = 0;
        while (!ready && n < 20) begin @(negedge clk); n++; end
        csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_rs1 = rs1; csr_imm = imm;
        @(posedge clk); #1;
        csr_req = 1'b0; csr_rs1 = '1; csr_addr = 12'hFFF;
        n = 0;
        @(negedge clk);
        while (!csr_done && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL %s_timeout: no csr_done within 20 cycles, expected one", nm);
        end
    endtask

    task automatic run_redirect(input string nm, input bit is_mret, input logic [63:0] pc,
                                input logic [63:0] cause, input logic [63:0] tval,
                                input logic [63:0] exp_pc, output int cyc);
        int n;
        rdr_q.push_back('{nm, exp_pc, 1'b0, 1'b0});
        @(negedge clk);
        n = 0;
        while (!ready && n < 20) begin @(negedge clk); n++; end
        if (is_mret) mret_req = 1'b1;
        else begin trap_req = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval; end
        @(posedge clk); #1;
        trap_req = 1'b0; mret_req = 1'b0;
        trap_pc = '1; trap_cause = '1; trap_tval = '1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!redirect_valid && cyc < 20);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: ready=%b expected 1", ready); else n_pass++;
        n_checks++; if (csr_done !== 1'b0) $display("FAIL reset_done: csr_done=%b expected 0", csr_done); else n_pass++;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect: redirect_valid=%b expected 0", redirect_valid); else n_pass++;
        n_checks++; if (csr_rd_val !== 64'h0) $display("FAIL reset_rd_val: csr_rd_val=%h expected 0", csr_rd_val); else n_pass++;
        run_csr("reset_mstatus", RS, 12'h300, 64'h0, 5'h0, 64'h1800, 1'b0);
        run_csr("reset_mcause",  RS, 12'h342, 64'h0, 5'h0, 64'h0, 1'b0);
        run_csr("reset_mtvec",   RS, 12'h305, 64'h0, 5'h0, 64'h0, 1'b0);
    endtask

    task automatic test_rw_rs;
        run_csr("rw_mscratch",   RW,  12'h340, 64'hDEAD, 5'h0,  64'h0,    1'b0);
        run_csr("rs_mscratch",   RS,  12'h340, 64'h0F00, 5'h0,  64'hDEAD, 1'b0);
        run_csr("read_dfad",     RS,  12'h340, 64'h0,    5'h0,  64'hDFAD, 1'b0);
        run_csr("rci_mscratch",  RCI, 12'h340, 64'h0,    5'h0D, 64'hDFAD, 1'b0);
        run_csr("rsi_mscratch",  RSI, 12'h340, 64'h0,    5'h1F, 64'hDFA0, 1'b0);
        run_csr("rc_mscratch",   RC,  12'h340, 64'hFF00, 5'h0,  64'hDFBF, 1'b0);
        run_csr("rwi_mscratch",  RWI, 12'h340, 64'h0,    5'h12, 64'h00BF, 1'b0);
        run_csr("read_rwi",      RS,  12'h340, 64'h0,    5'h0,  64'h12,   1'b0);
    endtask

    task automatic test_fields;
        run_csr("mstatus_w1",    RW, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 5'h0, 64'h1800, 1'b0);
        run_csr("mstatus_w2",    RW, 12'h300, 64'h8,    5'h0, 64'h1888, 1'b0);
        run_csr("mstatus_rd",    RS, 12'h300, 64'h0,    5'h0, 64'h1808, 1'b0);
        run_csr("mtvec_w_mode3", RW, 12'h305, 64'h1003, 5'h0, 64'h0,    1'b0);
        run_csr("mtvec_w_mode2", RW, 12'h305, 64'h1002, 5'h0, 64'h1000, 1'b0);
        run_csr("mtvec_w_mode0", RW, 12'h305, 64'h1000, 5'h0, 64'h1000, 1'b0);
        run_csr("mepc_w",        RW, 12'h341, 64'h2003, 5'h0, 64'h0,    1'b0);
        run_csr("mepc_align",    RS, 12'h341, 64'h0,    5'h0, 64'h2000, 1'b0);
        run_csr("mie_w",         RW, 12'h304, 64'hAAA,  5'h0, 64'h0,    1'b0);
        run_csr("mie_rd",        RS, 12'h304, 64'h0,    5'h0, 64'hAAA,  1'b0);
    endtask

    task automatic test_trap_priority;
        int cyc, rcyc, dcyc;
        exp_q.push_back('{"trap_then_csr", 64'h12, 1'b0, 1'b0});
        rdr_q.push_back('{"trap_redirect", 64'h1000, 1'b0, 1'b0});
        @(negedge clk);
        csr_req = 1'b1; csr_op = RS; csr_addr = 12'h340; csr_rs1 = 64'h0; csr_imm = 5'h0;
        trap_req = 1'b1; trap_pc = 64'h8000_0010; trap_cause = 64'h2; trap_tval = 64'hBAD;
        @(posedge clk); #1;
        trap_req = 1'b0; trap_pc = '1; trap_cause = '1; trap_tval = '1;
        cyc = 0; rcyc = 0; dcyc = 0;
        while (cyc < 20 && dcyc == 0) begin
            @(negedge clk); cyc++;
            if (redirect_valid && rcyc == 0) rcyc = cyc;
            if (csr_done) begin dcyc = cyc; csr_req = 1'b0; end
        end
        csr_req = 1'b0;
        n_checks++; if (rcyc != 3) $display("FAIL trap_latency: redirect at cycle %0d expected 3", rcyc); else n_pass++;
        n_checks++; if (dcyc != 5) $display("FAIL held_csr_latency: done at cycle %0d expected 5", dcyc); else n_pass++;
        run_csr("trap_mepc",    RS, 12'h341, 64'h0, 5'h0, 64'h8000_0010, 1'b0);
        run_csr("trap_mcause",  RS, 12'h342, 64'h0, 5'h0, 64'h2,         1'b0);
        run_csr("trap_mtval",   RS, 12'h343, 64'h0, 5'h0, 64'hBAD,       1'b0);
        run_csr("trap_mstatus", RS, 12'h300, 64'h0, 5'h0, 64'h1880,      1'b0);
    endtask

    task automatic test_vectored;
        int cyc;
        run_csr("mtvec_vec", RW, 12'h305, 64'h1001, 5'h0, 64'h1000, 1'b0);
        run_redirect("vec_irq_redirect", 1'b0, 64'h3006, 64'h8000_0000_0000_0007, 64'h0, 64'h101C, cyc);
        n_checks++; if (cyc != 3) $display("FAIL vec_latency: redirect at cycle %0d expected 3", cyc); else n_pass++;
        run_csr("vec_mepc",    RS, 12'h341, 64'h0, 5'h0, 64'h3004, 1'b0);
        run_csr("vec_mstatus", RS, 12'h300, 64'h0, 5'h0, 64'h1800, 1'b0);
        run_redirect("vec_exc_redirect", 1'b0, 64'h4000, 64'h5, 64'h77, 64'h1000, cyc);
        n_checks++; if (cyc != 3) $display("FAIL exc_latency: redirect at cycle %0d expected 3", cyc); else n_pass++;
        run_csr("exc_mcause", RS, 12'h342, 64'h0, 5'h0, 64'h5, 1'b0);
    endtask

    task automatic test_mret;
        int cyc;
        run_csr("mret_set_mepc",    RW, 12'h341, 64'h2000, 5'h0, 64'h4000, 1'b0);
        run_csr("mret_set_mstatus", RW, 12'h300, 64'h80,   5'h0, 64'h1800, 1'b0);
        run_redirect("mret_redirect", 1'b1, 64'h0, 64'h0, 64'h0, 64'h2000, cyc);
        n_checks++; if (cyc != 1) $display("FAIL mret_latency: redirect at cycle %0d expected 1", cyc); else n_pass++;
        run_csr("mret_mstatus", RS, 12'h300, 64'h0, 5'h0, 64'h1888, 1'b0);
    endtask

    task automatic test_illegal;
        run_csr("illegal_addr",  RW, 12'h7C0, 64'h55, 5'h0, 64'h0, 1'b1);
        run_csr("illegal_op0",   4'd0,  12'h340, 64'h99, 5'h0, 64'h0, 1'b1);
        run_csr("illegal_op7",   4'd7,  12'h340, 64'h99, 5'h0, 64'h0, 1'b1);
        run_csr("illegal_op15",  4'd15, 12'h340, 64'h99, 5'h3, 64'h0, 1'b1);
        run_csr("illegal_nochg", RS, 12'h340, 64'h0, 5'h0, 64'h12, 1'b0);
`ifndef CSR_PERF_CNT_EN
        run_csr("mcycle_absent",   RW, 12'hB00, 64'h5, 5'h0, 64'h0, 1'b1);
        run_csr("minstret_absent", RS, 12'hB02, 64'h5, 5'h0, 64'h0, 1'b1);
`endif
    endtask

`ifdef CSR_PERF_CNT_EN
    task automatic test_perf_counters;
        run_csr("mcycle_w",    RW, 12'hB00, 64'h100, 5'h0, 64'h0, 1'b0, 1'b1);
        run_csr("mcycle_rd",   RS, 12'hB00, 64'h0,   5'h0, 64'h100, 1'b0);
        run_csr("minstret_w",  RW, 12'hB02, 64'h50,  5'h0, 64'h0, 1'b0, 1'b1);
        repeat (3) begin @(negedge clk); instret = 1'b1; end
        @(negedge clk); instret = 1'b0;
        run_csr("minstret_rd", RS, 12'hB02, 64'h0, 5'h0, 64'h53, 1'b0);
    endtask
`endif

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        trap_req = 1'b1; trap_pc = 64'h5550; trap_cause = 64'hB; trap_tval = 64'h1;
        @(posedge clk); #1;
        trap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL midrst_ready: ready=%b expected 1", ready); else n_pass++;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL midrst_redirect: redirect_valid=%b expected 0", redirect_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (redirect_valid) seen++; end
        n_checks++; if (seen != 0) $display("FAIL midrst_resumed: %0d redirects after reset, expected 0", seen); else n_pass++;
        run_csr("midrst_mstatus",  RS, 12'h300, 64'h0, 5'h0, 64'h1800, 1'b0);
        run_csr("midrst_mcause",   RS, 12'h342, 64'h0, 5'h0, 64'h0,    1'b0);
        run_csr("midrst_mepc",     RS, 12'h341, 64'h0, 5'h0, 64'h0,    1'b0);
        run_csr("midrst_mscratch", RS, 12'h340, 64'h0, 5'h0, 64'h0,    1'b0);
    endtask

    initial begin
        test_reset();
        test_rw_rs();
        test_fields();
        test_trap_priority();
        test_vectored();
        test_mret();
        test_illegal();
`ifdef CSR_PERF_CNT_EN
        test_perf_counters();
`endif
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || rdr_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d completions and %0d redirects outstanding, expected 0",
                     exp_q.size(), rdr_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
